// File: rtl/pipe_column_tracker.sv
// Pipe-column tracker: scrolls 8-bit pipe patterns across the playfield,
// decodes the gap at the bird column, detects collisions and keeps score.
//
// Ports:
//   Clock, Reset        : clock, synchronous active-high reset
//   start               : begin or restart a game
//   shift               : one-cycle scroll tick
//   col_in[7:0]         : pattern entering the rightmost column
//   bird_row[2:0]       : bird row (row r = bit r)
//   rd_col[3:0]         : display read column
//   rd_data[7:0]        : pattern at rd_col (0 when out of range)
//   gap_idx, gap_valid  : decoded gap of the bird column
//   collide, running    : game-phase flags
//   score_pulse, score  : passed-pipe pulse and saturating count
module pipe_column_tracker #(
  parameter int COLS     = 8,
  parameter int BIRD_COL = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       shift,
  input  logic [7:0] col_in,
  input  logic [2:0] bird_row,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_data,
  output logic [2:0] gap_idx,
  output logic       gap_valid,
  output logic       collide,
  output logic       score_pulse,
  output logic [7:0] score,
  output logic       running
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] col_q [COLS];
  logic [7:0] col_d [COLS];
  logic [7:0] score_q, score_d;
  logic       score_pulse_q, score_pulse_d;

  logic [7:0] bird_col;
  logic       hit;

  assign bird_col = col_q[BIRD_COL];
  assign hit      = (state_q == S_RUN) && bird_col[bird_row];

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    score_d       = score_q;
    score_pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        // A collision this cycle wins over any scroll tick.
        if (hit) begin
          state_d = S_OVER;
        end else if (shift) begin
          for (int i = 0; i < COLS - 1; i++)
            col_d[i] = col_q[i+1];
          col_d[COLS-1] = col_in;
          if (bird_col != 8'h00) begin
            score_pulse_d = 1'b1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          state_d = S_RUN;
          score_d = 8'h00;
          for (int i = 0; i < COLS; i++)
            col_d[i] = 8'h00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      score_q       <= 8'h00;
      score_pulse_q <= 1'b0;
      for (int i = 0; i < COLS; i++)
        col_q[i] <= 8'h00;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      score_pulse_q <= score_pulse_d;
      col_q         <= col_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < COLS; i++)
      if (rd_col == 4'(i)) rd_data = col_q[i];
  end

  always_comb begin
    gap_idx   = 3'd7;
    gap_valid = 1'b0;
    case (bird_col)
      8'b1001_1111: begin gap_idx = 3'd0; gap_valid = 1'b1; end
      8'b1100_1111: begin gap_idx = 3'd1; gap_valid = 1'b1; end
      8'b1110_0111: begin gap_idx = 3'd2; gap_valid = 1'b1; end
      8'b1111_0011: begin gap_idx = 3'd3; gap_valid = 1'b1; end
      8'b1111_1001: begin gap_idx = 3'd4; gap_valid = 1'b1; end
      8'b1100_0011: begin gap_idx = 3'd5; gap_valid = 1'b1; end
      default: ;
    endcase
  end

  assign collide     = (state_q == S_OVER);
  assign running     = (state_q == S_RUN);
  assign score       = score_q;
  assign score_pulse = score_pulse_q;

endmodule

// File: tb/tb_pipe_column_tracker.sv
// Self-checking bench for pipe_column_tracker: a behavioural game model
// feeds a scoreboard queue, plus directed checks of key scenarios.
module tb_pipe_column_tracker;
  localparam int COLS = 8;
  localparam int BIRD = 1;

  logic       Clock = 1'b0;
  logic       Reset, start, shift;
  logic [7:0] col_in;
  logic [2:0] bird_row;
  logic [3:0] rd_col;
  logic [7:0] rd_data, score;
  logic [2:0] gap_idx;
  logic       gap_valid, collide, score_pulse, running;

  pipe_column_tracker #(.COLS(COLS), .BIRD_COL(BIRD)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .shift(shift),
    .col_in(col_in), .bird_row(bird_row), .rd_col(rd_col),
    .rd_data(rd_data), .gap_idx(gap_idx), .gap_valid(gap_valid),
    .collide(collide), .score_pulse(score_pulse), .score(score),
    .running(running)
  );

  always #20 Clock = ~Clock;

  typedef struct packed {
    logic [COLS*8-1:0] cols;
    logic [7:0]        score;
    logic              pulse;
    logic              collide;
    logic              running;
    logic [2:0]        gidx;
    logic              gv;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int pulses_seen = 0;

  // Reference model: 0 idle, 1 run, 2 over
  logic [7:0] m_cols [COLS];
  int         m_st;
  logic [7:0] m_score;
  logic       m_pulse;

  function automatic void gap_ref(input logic [7:0] c,
                                  output logic [2:0] g,
                                  output logic v);
    g = 3'd7; v = 1'b0;
    if (c == 8'h9F) begin g = 3'd0; v = 1'b1; end
    if (c == 8'hCF) begin g = 3'd1; v = 1'b1; end
    if (c == 8'hE7) begin g = 3'd2; v = 1'b1; end
    if (c == 8'hF3) begin g = 3'd3; v = 1'b1; end
    if (c == 8'hF9) begin g = 3'd4; v = 1'b1; end
    if (c == 8'hC3) begin g = 3'd5; v = 1'b1; end
  endfunction

  task automatic step(input logic rst, input logic st, input logic sh,
                      input logic [7:0] ci, input logic [2:0] br);
    exp_t e, a;
    logic [7:0] pre;
    Reset = rst; start = st; shift = sh; col_in = ci; bird_row = br;
    m_pulse = 1'b0;
    if (rst) begin
      m_st = 0; m_score = 8'h00;
      for (int i = 0; i < COLS; i++) m_cols[i] = 8'h00;
    end else if (m_st == 0) begin
      if (st) m_st = 1;
    end else if (m_st == 1) begin
      pre = m_cols[BIRD];
      if (pre[br]) begin
        m_st = 2;
      end else if (sh) begin
        if (pre != 8'h00) begin
          m_pulse = 1'b1;
          if (m_score != 8'd255) m_score = m_score + 8'd1;
        end
        for (int i = 0; i < COLS - 1; i++) m_cols[i] = m_cols[i+1];
        m_cols[COLS-1] = ci;
      end
    end else if (st) begin
      m_st = 1; m_score = 8'h00;
      for (int i = 0; i < COLS; i++) m_cols[i] = 8'h00;
    end
    for (int i = 0; i < COLS; i++) e.cols[i*8 +: 8] = m_cols[i];
    e.score = m_score; e.pulse = m_pulse;
    e.collide = (m_st == 2); e.running = (m_st == 1);
    gap_ref(m_cols[BIRD], e.gidx, e.gv);
    q.push_back(e);

    @(posedge Clock); #1;
    e = q.pop_front();
    for (int i = 0; i <= COLS; i++) begin
      rd_col = 4'(i); #1;
      a.cols = '0;
      checks++;
      if (i < COLS) begin
        if (rd_data !== e.cols[i*8 +: 8]) begin
          errors++;
          $display("FAIL rd_data col %0d: got %h exp %h", i, rd_data,
                   e.cols[i*8 +: 8]);
        end
      end else if (rd_data !== 8'h00) begin
        errors++;
        $display("FAIL rd_data out-of-range: got %h exp 00", rd_data);
      end
    end
    a = '{cols: '0, score: score, pulse: score_pulse, collide: collide,
          running: running, gidx: gap_idx, gv: gap_valid};
    e.cols = '0;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL status: got sc=%0d p=%b c=%b r=%b g=%0d v=%b exp sc=%0d p=%b c=%b r=%b g=%0d v=%b",
               a.score, a.pulse, a.collide, a.running, a.gidx, a.gv,
               e.score, e.pulse, e.collide, e.running, e.gidx, e.gv);
    end
    if (score_pulse === 1'b1) pulses_seen++;
  endtask

  task automatic read_col(input int c, output logic [7:0] d);
    rd_col = 4'(c); #1; d = rd_data;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 8'h00, 3'd0);
    checks++;
    if (score !== 8'd0 || running !== 1'b0 || collide !== 1'b0 ||
        score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: got sc=%0d r=%b c=%b p=%b exp 0 0 0 0",
               score, running, collide, score_pulse);
    end
    step(0, 0, 1, 8'hFF, 3'd0);
  endtask

  task automatic test_empty_scroll();
    step(0, 1, 0, 8'h00, 3'd3);
    pulses_seen = 0;
    for (int k = 0; k < 8; k++) step(0, 0, 1, 8'h00, 3'd3);
    checks++;
    if (running !== 1'b1 || collide !== 1'b0 || score !== 8'd0 ||
        pulses_seen != 0) begin
      errors++;
      $display("FAIL empty_scroll: got r=%b c=%b sc=%0d pulses=%0d exp 1 0 0 0",
               running, collide, score, pulses_seen);
    end
  endtask

  task automatic test_pass_pipe();
    step(0, 0, 1, 8'h9F, 3'd5);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 8'h00, 3'd5);
    checks++;
    if (gap_idx !== 3'd0 || gap_valid !== 1'b1) begin
      errors++;
      $display("FAIL pass_gap: got g=%0d v=%b exp 0 1", gap_idx, gap_valid);
    end
    step(0, 0, 1, 8'h00, 3'd5);
    checks++;
    if (score_pulse !== 1'b1 || score !== 8'd1 || collide !== 1'b0) begin
      errors++;
      $display("FAIL pass_score: got p=%b sc=%0d c=%b exp 1 1 0",
               score_pulse, score, collide);
    end
    step(0, 0, 0, 8'h00, 3'd5);
    checks++;
    if (score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pass_pulse_width: got %b exp 0", score_pulse);
    end
  endtask

  task automatic test_collide();
    logic [7:0] d;
    step(1, 0, 0, 8'h00, 3'd0);
    step(0, 1, 0, 8'h00, 3'd0);
    step(0, 0, 1, 8'h9F, 3'd0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 8'h00, 3'd0);
    checks++;
    if (collide !== 1'b0) begin
      errors++;
      $display("FAIL collide_early: got %b exp 0", collide);
    end
    step(0, 0, 0, 8'h00, 3'd0);
    checks++;
    if (collide !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL collide_rise: got c=%b r=%b exp 1 0", collide, running);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 1, 8'hFF, 3'd0);
    read_col(BIRD, d);
    checks++;
    if (d !== 8'h9F || score !== 8'd0) begin
      errors++;
      $display("FAIL over_frozen: got col=%h sc=%0d exp 9f 0", d, score);
    end
  endtask

  task automatic test_restart();
    step(0, 1, 0, 8'h00, 3'd0);
    checks++;
    if (score !== 8'd0 || collide !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL restart: got sc=%0d c=%b r=%b exp 0 0 1",
               score, collide, running);
    end
  endtask

  task automatic test_hit_with_shift();
    logic [7:0] d7, d1;
    step(0, 0, 1, 8'h9F, 3'd5);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 8'h00, 3'd5);
    step(0, 0, 1, 8'hFF, 3'd0);
    read_col(COLS - 1, d7);
    read_col(BIRD, d1);
    checks++;
    if (d7 !== 8'h00 || d1 !== 8'h9F || collide !== 1'b1 ||
        score !== 8'd0 || score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL hit_shift: got c7=%h c1=%h c=%b sc=%0d p=%b exp 00 9f 1 0 0",
               d7, d1, collide, score, score_pulse);
    end
    step(0, 1, 0, 8'h00, 3'd0);
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 262; k++) step(0, 0, 1, 8'h9F, 3'd5);
    checks++;
    if (score !== 8'd255) begin
      errors++;
      $display("FAIL sat_reach: got %0d exp 255", score);
    end
    step(0, 0, 1, 8'h9F, 3'd5);
    checks++;
    if (score !== 8'd255 || score_pulse !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: got sc=%0d p=%b exp 255 1", score, score_pulse);
    end
  endtask

  task automatic test_reset_midgame();
    logic [7:0] d;
    step(1, 0, 1, 8'hFF, 3'd5);
    checks++;
    if (score !== 8'd0 || running !== 1'b0 || collide !== 1'b0 ||
        score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got sc=%0d r=%b c=%b p=%b exp 0 0 0 0",
               score, running, collide, score_pulse);
    end
    step(0, 0, 1, 8'hFF, 3'd5);
    read_col(COLS - 1, d);
    checks++;
    if (d !== 8'h00 || running !== 1'b0) begin
      errors++;
      $display("FAIL idle_shift: got c7=%h r=%b exp 00 0", d, running);
    end
    step(0, 1, 0, 8'h00, 3'd5);
    step(0, 0, 1, 8'hE7, 3'd5);
    step(0, 0, 0, 8'h00, 3'd5);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; shift = 1'b0;
    col_in = 8'h00; bird_row = 3'd0; rd_col = 4'd0;
    #5;
    test_reset();
    test_empty_scroll();
    test_pass_pipe();
    test_collide();
    test_restart();
    test_hit_with_shift();
    test_saturate();
    test_reset_midgame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_column_tracker.md
Name: pipe_column_tracker

Overview:
- Receiving end of the pipe-column generator: accepts 8-bit column patterns (bit=1 pipe, bit=0 gap), scrolls them right-to-left across a COLS-wide playfield, decodes the gap at the bird column, detects bird/pipe collision and counts passed pipes.
- Sits between the column generator and the LED-matrix driver and score display.
- A game-phase FSM gates scrolling and scoring.

Parameters:
- COLS, 8, playfield width in columns (2..16).
- BIRD_COL, 1, column index the bird occupies (0..COLS-2).

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  level/pulse; begins or restarts a game
- shift  in  1  one-cycle scroll tick
- col_in  in  8  pattern entering at column COLS-1 on shift
- bird_row  in  3  bird row 0..7 (row r = bit r)
- rd_col  in  4  display read column index
- rd_data  out  8  column pattern at rd_col (combinational; 0 if rd_col>=COLS)
- gap_idx  out  3  decoded gap code of column BIRD_COL
- gap_valid  out  1  column BIRD_COL holds a legal pipe pattern
- collide  out  1  high while in OVER
- score_pulse  out  1  one-cycle pulse per passed pipe
- score  out  8  passed-pipe count, saturating at 255
- running  out  1  high while in RUN

Behaviour:
- Reset: Reset, synchronous, active-high; clock Clock. On Reset:
  - all columns = 8'h00, state=IDLE
  - score=0; score_pulse=0, collide=0, running=0
  - Reset mid-game aborts immediately; takes priority over all inputs.
- States:
  - IDLE: columns frozen, shift ignored. start -> RUN; columns are not cleared on this transition.
  - RUN: scrolls on shift. Hit (below) -> OVER.
  - OVER: columns and score frozen, collide=1, shift ignored. start -> clear columns and score, score_pulse=0, then RUN.
- Scroll: on shift in RUN with no hit this cycle:
  - col[i] <= col[i+1] for i<COLS-1; col[COLS-1] <= col_in; col[0] is discarded.
  - New contents are visible on rd_data the cycle after the edge.
- Hit: evaluated every RUN cycle on registered state.
  - hit = col[BIRD_COL][bird_row].
  - Next edge: state=OVER, collide=1. Any shift in that cycle is discarded (collision wins).
  - The scoring rule below does not apply on that cycle.
- Score:
  - On an accepted shift where col[BIRD_COL] != 0 (pre-shift value), score increments (saturating at 255) and score_pulse=1 for exactly the next cycle.
  - Empty columns (8'h00) never score.
- Gap decode of col[BIRD_COL] (combinational, pure function of register):
  - 8'b10011111->0, 11001111->1, 11100111->2, 11110011->3, 11111001->4, 11000011->5; for these gap_valid=1.
  - 8'h00 -> gap_idx=7, gap_valid=0 (empty column).
  - Any other pattern -> gap_idx=7, gap_valid=0. Collision still uses the raw bits.
- Latency:
  - shift -> score/score_pulse: 1 cycle.
  - Hit condition -> collide: 1 cycle.
  - rd_data, gap_idx: 0 cycles from register.
- start while in RUN: ignored.
- bird_row: may change any cycle; only its value at the evaluating edge matters.

Test Plan:
- Reset, start, 8 shifts of col_in=8'h00 with bird_row=3 -> running=1, no collide, score=0, score_pulse never asserted.
- Feed 8'b10011111 then 8'h00 shifts, bird_row=5: after the pipe reaches BIRD_COL, gap_idx=0, gap_valid=1. Next shift -> score_pulse one cycle, score=1, no collide.
- Same pipe with bird_row=0:
  - collide rises 1 cycle after the pipe reaches BIRD_COL; state OVER.
  - Further shifts leave rd_data unchanged; score stays 0.
- Hit condition and shift in the same cycle -> shift discarded (rd_data unchanged), collide=1, score not incremented.
- In OVER, pulse start -> all rd_data=0, score=0, collide=0, running=1.
- Force score=255 via 255 passed pipes; next passed pipe -> score stays 255, score_pulse still pulses.
- Assert Reset mid-RUN with nonzero columns -> next cycle all outputs at reset values, state IDLE; shift ignored until start.
